gelato_reg_wb_arbiter: RTL and testbench
========================================

Name: gelato_reg_wb_arbiter

Overview:
- Collects register writeback requests from the execution units (ALU, load/store unit) and serialises them onto the single register-file write port.
- Sits between the execute stage's reg_wb masters and the warp register file.
- Uses the valid/caught writeback handshake: a producer holds valid and payload until it sees caught.
- Arbitration is round-robin. Each granted request produces one registered write, one cycle after acceptance.

Parameters:
- N_SRC, 2, number of writeback sources (index 0 = ALU, 1 = LSU).
- THREAD_NUM, 32, threads per warp; width of the thread mask.
- DATA_WIDTH, 32, bits per thread lane.
- REG_W, 5, register number width.
- WARP_W, 4, warp number width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; when 0, no new grants are made.
- src_valid  in  N_SRC  per-source writeback request.
- src_reg_num  in  N_SRC*REG_W  per-source destination register.
- src_warp_num  in  N_SRC*WARP_W  per-source warp number.
- src_thread_mask  in  N_SRC*THREAD_NUM  per-source active lanes.
- src_data  in  N_SRC*THREAD_NUM*DATA_WIDTH  per-source warp data.
- src_caught  out  N_SRC  one-cycle acceptance pulse per source.
- rf_we  out  1  register-file write enable, one cycle per write.
- rf_reg_num  out  REG_W  write register.
- rf_warp_num  out  WARP_W  write warp.
- rf_thread_mask  out  THREAD_NUM  lanes to write; masked lanes are untouched.
- rf_data  out  THREAD_NUM*DATA_WIDTH  write data.
- busy  out  1  high while any src_valid is pending and not yet caught.

Behaviour:
- Reset values (async, on rst_n=0):
  - src_caught=0, rf_we=0.
  - rf_reg_num, rf_warp_num, rf_thread_mask and rf_data all 0.
  - Round-robin pointer last_grant=N_SRC-1, so source 0 wins first.
- Reset mid-operation drops any in-flight grant. Producers must re-present their request after reset.
- Eligibility: source i is eligible when src_valid[i]=1 and src_caught[i]=0 in the current cycle. A source being acknowledged this cycle cannot be re-granted on its stale valid.
- Arbitration, at each posedge with rdy=1:
  - Pick the first eligible source searching from last_grant+1, wrapping modulo N_SRC.
  - Update last_grant to the winner.
  - If no source is eligible, last_grant holds.
- Latency: request sampled at edge t → at edge t+1 (visible in cycle t+1):
  - src_caught[winner]=1 and all other src_caught bits = 0.
  - rf_we=1, with the rf_* payload copied from the winner.
  - Exactly one grant per cycle; throughput is 1 write/cycle.
- Producer rule: drop or replace valid in the cycle after caught is seen. The arbiter never accepts the same request twice.
- Null writes: if the winner has reg_num==0 or thread_mask==0:
  - It is still caught (src_caught pulses).
  - rf_we stays 0; x0 is hardwired.
- rdy=0 at an edge:
  - No grant.
  - src_caught and rf_we go 0.
  - rf_* payload and last_grant hold.
  - Pending requests wait; no request is lost.
- Simultaneous requests: the loser remains valid and is granted on a later cycle. With N_SRC=2 and both sources continuously requesting, grants alternate 0,1,0,1.
- Ordering: two writes to the same (warp, reg) are committed in grant order. The producer issue order determines correctness; the arbiter adds no reordering beyond arbitration.
- busy is combinational: OR over i of (src_valid[i] & ~src_caught[i]).
- All payload widths pass through unmodified; there is no arithmetic on data.

Test Plan:
- Reset then single request:
  - Stimulus: src1 valid, reg=3, warp=2, mask=0x0000_00FF, data lanes = lane index.
  - Required: rf_we=1 and src_caught[1]=1 exactly one cycle later, payload matches; after src1 drops valid, rf_we=0 and busy=0.
- Contention:
  - Stimulus: src0 and src1 valid in the same cycle and held, each re-presenting a new request after caught.
  - Required: first grants go 0,1,0,1 over four cycles; neither source starves; no duplicate grant of a single request.
- Null write:
  - Stimulus: src0 request with reg=0, mask=0xFFFF_FFFF; then a request with reg=5, mask=0.
  - Required: src_caught[0] pulses both times, rf_we stays 0 both times.
- rdy stall:
  - Stimulus: rdy=0 for 3 cycles while src1 is valid.
  - Required: no caught and rf_we=0 during the stall; grant arrives the cycle after rdy returns to 1; the payload from before the stall holds through the stall.
- Async reset mid-operation:
  - Stimulus: assert rst_n=0 in the cycle rf_we=1.
  - Required: rf_we and src_caught go 0 immediately; the next grant after release goes to src0 when both sources request.
- Back-to-back from one source:
  - Stimulus: src1 presents request A, then request B the cycle after caught.
  - Required: two rf_we pulses separated by exactly one idle cycle; A is never written twice.

Source files
------------

// File: rtl/gelato_reg_wb_arbiter_if.sv
// Register writeback bundle: per-source valid/caught requests plus the
// serialised register-file write port driven by the arbiter.
interface gelato_reg_wb_arbiter_if #(
   parameter int unsigned N_SRC      = 2,
   parameter int unsigned THREAD_NUM = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_W      = 5,
   parameter int unsigned WARP_W     = 4
);
   logic [N_SRC-1:0]                       src_valid;
   logic [N_SRC*REG_W-1:0]                 src_reg_num;
   logic [N_SRC*WARP_W-1:0]                src_warp_num;
   logic [N_SRC*THREAD_NUM-1:0]            src_thread_mask;
   logic [N_SRC*THREAD_NUM*DATA_WIDTH-1:0] src_data;
   logic [N_SRC-1:0]                       src_caught;

   logic                                   rf_we;
   logic [REG_W-1:0]                       rf_reg_num;
   logic [WARP_W-1:0]                      rf_warp_num;
   logic [THREAD_NUM-1:0]                  rf_thread_mask;
   logic [THREAD_NUM*DATA_WIDTH-1:0]       rf_data;
   logic                                   busy;

   modport master (
      output src_valid, src_reg_num, src_warp_num, src_thread_mask, src_data,
      input  src_caught, rf_we, rf_reg_num, rf_warp_num, rf_thread_mask, rf_data, busy
   );

   modport slave (
      input  src_valid, src_reg_num, src_warp_num, src_thread_mask, src_data,
      output src_caught, rf_we, rf_reg_num, rf_warp_num, rf_thread_mask, rf_data, busy
   );
endinterface

// File: rtl/gelato_reg_wb_arbiter.sv
// Round-robin writeback arbiter: serialises per-source valid/caught requests
// onto the single register-file write port, one registered write per grant.
module gelato_reg_wb_arbiter #(
   parameter int unsigned N_SRC      = 2,
   parameter int unsigned THREAD_NUM = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_W      = 5,
   parameter int unsigned WARP_W     = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rdy,
   gelato_reg_wb_arbiter_if.slave  wb
);
   localparam int unsigned IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int unsigned LANE_W = THREAD_NUM * DATA_WIDTH;

   logic [N_SRC-1:0]      r_caught;
   logic [IDX_W-1:0]      r_last_grant;
   logic                  r_we;
   logic [REG_W-1:0]      r_reg_num;
   logic [WARP_W-1:0]     r_warp_num;
   logic [THREAD_NUM-1:0] r_thread_mask;
   logic [LANE_W-1:0]     r_data;

   logic [N_SRC-1:0]      w_elig;
   logic                  w_found;
   logic [IDX_W-1:0]      w_win;
   logic [REG_W-1:0]      w_reg_num;
   logic [WARP_W-1:0]     w_warp_num;
   logic [THREAD_NUM-1:0] w_thread_mask;
   logic [LANE_W-1:0]     w_data;
   logic                  w_null;

   // A source acknowledged this cycle still shows its stale valid; mask it out.
   assign w_elig = wb.src_valid & ~r_caught;

   // Search above last_grant first, then wrap to the lowest eligible index.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (!w_found && w_elig[i] && (i > 32'(r_last_grant))) begin
            w_found = 1'b1;
            w_win   = IDX_W'(i);
         end
      end
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (!w_found && w_elig[i]) begin
            w_found = 1'b1;
            w_win   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      w_reg_num     = '0;
      w_warp_num    = '0;
      w_thread_mask = '0;
      w_data        = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (IDX_W'(i) == w_win) begin
            w_reg_num     = wb.src_reg_num[i*REG_W +: REG_W];
            w_warp_num    = wb.src_warp_num[i*WARP_W +: WARP_W];
            w_thread_mask = wb.src_thread_mask[i*THREAD_NUM +: THREAD_NUM];
            w_data        = wb.src_data[i*LANE_W +: LANE_W];
         end
      end
   end

   // Register x0 is hardwired and an empty mask writes nothing.
   assign w_null = (w_reg_num == '0) || (w_thread_mask == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_caught      <= '0;
         r_last_grant  <= IDX_W'(N_SRC - 1);
         r_we          <= 1'b0;
         r_reg_num     <= '0;
         r_warp_num    <= '0;
         r_thread_mask <= '0;
         r_data        <= '0;
      end else begin
         r_caught <= '0;
         r_we     <= 1'b0;
         if (rdy && w_found) begin
            r_caught      <= N_SRC'(1) << w_win;
            r_last_grant  <= w_win;
            r_we          <= !w_null;
            r_reg_num     <= w_reg_num;
            r_warp_num    <= w_warp_num;
            r_thread_mask <= w_thread_mask;
            r_data        <= w_data;
         end
      end
   end

   assign wb.src_caught     = r_caught;
   assign wb.rf_we          = r_we;
   assign wb.rf_reg_num     = r_reg_num;
   assign wb.rf_warp_num    = r_warp_num;
   assign wb.rf_thread_mask = r_thread_mask;
   assign wb.rf_data        = r_data;
   assign wb.busy           = |w_elig;
endmodule

// File: tb/tb_gelato_reg_wb_arbiter.sv
// Scenario bench for the writeback arbiter: requests push expected writes to a
// queue in predicted grant order; each scenario pops and compares at grant time.
module tb_gelato_reg_wb_arbiter;
   localparam int unsigned N_SRC      = 2;
   localparam int unsigned THREAD_NUM = 32;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned REG_W      = 5;
   localparam int unsigned WARP_W     = 4;
   localparam int unsigned LW         = THREAD_NUM * DATA_WIDTH;

   logic clk = 1'b0;
   logic rst_n;
   logic rdy;

   always #5 clk = ~clk;

   gelato_reg_wb_arbiter_if #(
      .N_SRC(N_SRC), .THREAD_NUM(THREAD_NUM), .DATA_WIDTH(DATA_WIDTH),
      .REG_W(REG_W), .WARP_W(WARP_W)
   ) ifc ();

   gelato_reg_wb_arbiter #(
      .N_SRC(N_SRC), .THREAD_NUM(THREAD_NUM), .DATA_WIDTH(DATA_WIDTH),
      .REG_W(REG_W), .WARP_W(WARP_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rdy(rdy),
      .wb(ifc)
   );

   typedef struct {
      int unsigned           src;
      logic                  we;
      logic [REG_W-1:0]      rn;
      logic [WARP_W-1:0]     wn;
      logic [THREAD_NUM-1:0] mask;
      logic [LW-1:0]         data;
   } wr_t;

   wr_t sb[$];
   int  n_chk  = 0;
   int  n_fail = 0;

   function automatic logic [LW-1:0] mk_data(input int unsigned seed);
      logic [LW-1:0] d;
      d = '0;
      for (int unsigned k = 0; k < THREAD_NUM; k++)
         d[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(seed * 256 + k);
      return d;
   endfunction

   task automatic present(input int unsigned s, input logic [REG_W-1:0] rn,
                          input logic [WARP_W-1:0] wn, input logic [THREAD_NUM-1:0] mask,
                          input logic [LW-1:0] data);
      wr_t e;
      ifc.src_valid[s]                                  = 1'b1;
      ifc.src_reg_num[s*REG_W +: REG_W]                 = rn;
      ifc.src_warp_num[s*WARP_W +: WARP_W]              = wn;
      ifc.src_thread_mask[s*THREAD_NUM +: THREAD_NUM]   = mask;
      ifc.src_data[s*LW +: LW]                          = data;
      e.src = s; e.rn = rn; e.wn = wn; e.mask = mask; e.data = data;
      e.we  = (rn != '0) && (mask != '0);
      sb.push_back(e);
   endtask

   task automatic drop(input int unsigned s);
      ifc.src_valid[s] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rdy   = 1'b1;
      ifc.src_valid = '0; ifc.src_reg_num = '0; ifc.src_warp_num = '0;
      ifc.src_thread_mask = '0; ifc.src_data = '0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (ifc.src_caught !== '0 || ifc.rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: caught=%b we=%b, required caught=00 we=0", ifc.src_caught, ifc.rf_we);
      end
      n_chk++;
      if (ifc.rf_reg_num !== '0 || ifc.rf_warp_num !== '0 || ifc.rf_thread_mask !== '0 || ifc.rf_data !== '0) begin
         n_fail++;
         $display("FAIL reset_payload: reg=%0d warp=%0d mask=%h lane0=%h, required all zero",
                  ifc.rf_reg_num, ifc.rf_warp_num, ifc.rf_thread_mask, ifc.rf_data[31:0]);
      end
      n_chk++;
      if (ifc.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: busy=%b, required 0", ifc.busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      wr_t e;
      sb.delete();
      present(1, 5'd3, 4'd2, 32'h0000_00FF, mk_data(0));
      #1;
      n_chk++;
      if (ifc.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_busy_pending: busy=%b, required 1", ifc.busy);
      end
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (ifc.src_caught !== (N_SRC'(1) << e.src) || ifc.rf_we !== e.we) begin
         n_fail++;
         $display("FAIL single_grant: caught=%b we=%b, required caught=%b we=%b",
                  ifc.src_caught, ifc.rf_we, N_SRC'(1) << e.src, e.we);
      end
      n_chk++;
      if ({ifc.rf_reg_num, ifc.rf_warp_num, ifc.rf_thread_mask, ifc.rf_data} !== {e.rn, e.wn, e.mask, e.data}) begin
         n_fail++;
         $display("FAIL single_payload: reg=%0d warp=%0d mask=%h lane1=%h, required reg=%0d warp=%0d mask=%h lane1=%h",
                  ifc.rf_reg_num, ifc.rf_warp_num, ifc.rf_thread_mask, ifc.rf_data[63:32], e.rn, e.wn, e.mask, e.data[63:32]);
      end
      drop(1);
      @(negedge clk);
      n_chk++;
      if (ifc.rf_we !== 1'b0 || ifc.src_caught !== '0 || ifc.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: we=%b caught=%b busy=%b, required we=0 caught=00 busy=0",
                  ifc.rf_we, ifc.src_caught, ifc.busy);
      end
   endtask

   task automatic test_contention();
      wr_t e;
      int unsigned n0, n1;
      sb.delete();
      present(0, 5'd1, 4'd1, '1, mk_data(10));
      present(1, 5'd2, 4'd1, '1, mk_data(20));
      n0 = 1; n1 = 1;
      for (int g = 0; g < 4; g++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (ifc.src_caught !== (N_SRC'(1) << e.src) || ifc.rf_we !== e.we) begin
            n_fail++;
            $display("FAIL contention_grant%0d: caught=%b we=%b, required caught=%b we=%b",
                     g, ifc.src_caught, ifc.rf_we, N_SRC'(1) << e.src, e.we);
         end
         n_chk++;
         if ({ifc.rf_reg_num, ifc.rf_warp_num, ifc.rf_thread_mask, ifc.rf_data} !== {e.rn, e.wn, e.mask, e.data}) begin
            n_fail++;
            $display("FAIL contention_payload%0d: reg=%0d lane1=%h, required reg=%0d lane1=%h",
                     g, ifc.rf_reg_num, ifc.rf_data[63:32], e.rn, e.data[63:32]);
         end
         if (e.src == 0) begin
            if (n0 < 2) begin present(0, 5'd11, 4'd1, '1, mk_data(11)); n0++; end
            else drop(0);
         end else begin
            if (n1 < 2) begin present(1, 5'd12, 4'd1, '1, mk_data(21)); n1++; end
            else drop(1);
         end
      end
      @(negedge clk);
      n_chk++;
      if (ifc.src_caught !== '0 || ifc.rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL contention_no_dup: caught=%b we=%b, required caught=00 we=0", ifc.src_caught, ifc.rf_we);
      end
   endtask

   task automatic test_null_write();
      wr_t e;
      sb.delete();
      present(0, 5'd0, 4'd4, 32'hFFFF_FFFF, mk_data(30));
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (ifc.src_caught !== 2'b01 || ifc.rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL null_write%0d: caught=%b we=%b, required caught=01 we=0", r, ifc.src_caught, ifc.rf_we);
         end
         if (r == 0) begin
            present(0, 5'd5, 4'd4, 32'h0000_0000, mk_data(31));
            @(negedge clk);
         end else begin
            drop(0);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_rdy_stall();
      wr_t e, held;
      sb.delete();
      present(0, 5'd7, 4'd3, 32'hF0F0_F0F0, mk_data(40));
      @(negedge clk);
      held = sb.pop_front();
      n_chk++;
      if (ifc.src_caught !== 2'b01 || ifc.rf_we !== 1'b1 || ifc.rf_reg_num !== held.rn) begin
         n_fail++;
         $display("FAIL stall_pre_grant: caught=%b we=%b reg=%0d, required caught=01 we=1 reg=%0d",
                  ifc.src_caught, ifc.rf_we, ifc.rf_reg_num, held.rn);
      end
      drop(0);
      @(negedge clk);
      rdy = 1'b0;
      present(1, 5'd12, 4'd5, 32'h0000_FFFF, mk_data(50));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_chk++;
         if (ifc.src_caught !== '0 || ifc.rf_we !== 1'b0 || ifc.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_ctrl%0d: caught=%b we=%b busy=%b, required caught=00 we=0 busy=1",
                     c, ifc.src_caught, ifc.rf_we, ifc.busy);
         end
         n_chk++;
         if ({ifc.rf_reg_num, ifc.rf_warp_num, ifc.rf_thread_mask, ifc.rf_data} !== {held.rn, held.wn, held.mask, held.data}) begin
            n_fail++;
            $display("FAIL stall_hold%0d: reg=%0d warp=%0d mask=%h, required reg=%0d warp=%0d mask=%h",
                     c, ifc.rf_reg_num, ifc.rf_warp_num, ifc.rf_thread_mask, held.rn, held.wn, held.mask);
         end
      end
      rdy = 1'b1;
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (ifc.src_caught !== (N_SRC'(1) << e.src) || ifc.rf_we !== e.we) begin
         n_fail++;
         $display("FAIL stall_release: caught=%b we=%b, required caught=%b we=%b",
                  ifc.src_caught, ifc.rf_we, N_SRC'(1) << e.src, e.we);
      end
      n_chk++;
      if ({ifc.rf_reg_num, ifc.rf_warp_num, ifc.rf_thread_mask, ifc.rf_data} !== {e.rn, e.wn, e.mask, e.data}) begin
         n_fail++;
         $display("FAIL stall_payload: reg=%0d mask=%h, required reg=%0d mask=%h",
                  ifc.rf_reg_num, ifc.rf_thread_mask, e.rn, e.mask);
      end
      drop(1);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      wr_t e;
      sb.delete();
      present(0, 5'd20, 4'd7, '1, mk_data(70));
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (ifc.src_caught !== 2'b01 || ifc.rf_we !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre: caught=%b we=%b, required caught=01 we=1", ifc.src_caught, ifc.rf_we);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (ifc.src_caught !== '0 || ifc.rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_async: caught=%b we=%b, required caught=00 we=0", ifc.src_caught, ifc.rf_we);
      end
      repeat (2) @(negedge clk);
      present(0, 5'd20, 4'd7, '1, mk_data(70));
      present(1, 5'd21, 4'd7, '1, mk_data(71));
      rst_n = 1'b1;
      for (int g = 0; g < 2; g++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (ifc.src_caught !== (N_SRC'(1) << e.src) || ifc.rf_we !== e.we || ifc.rf_reg_num !== e.rn) begin
            n_fail++;
            $display("FAIL midrst_grant%0d: caught=%b we=%b reg=%0d, required caught=%b we=%b reg=%0d",
                     g, ifc.src_caught, ifc.rf_we, ifc.rf_reg_num, N_SRC'(1) << e.src, e.we, e.rn);
         end
         drop(e.src);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      wr_t e;
      sb.delete();
      present(1, 5'd9, 4'd6, '1, mk_data(60));
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (ifc.src_caught !== 2'b10 || ifc.rf_we !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_grant%0d: caught=%b we=%b, required caught=10 we=1", r, ifc.src_caught, ifc.rf_we);
         end
         n_chk++;
         if ({ifc.rf_reg_num, ifc.rf_thread_mask, ifc.rf_data} !== {e.rn, e.mask, e.data}) begin
            n_fail++;
            $display("FAIL b2b_payload%0d: reg=%0d mask=%h lane1=%h, required reg=%0d mask=%h lane1=%h",
                     r, ifc.rf_reg_num, ifc.rf_thread_mask, ifc.rf_data[63:32], e.rn, e.mask, e.data[63:32]);
         end
         if (r == 0) present(1, 5'd10, 4'd6, 32'h8000_0001, mk_data(61));
         else drop(1);
         @(negedge clk);
         n_chk++;
         if (ifc.src_caught !== '0 || ifc.rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap%0d: caught=%b we=%b, required caught=00 we=0", r, ifc.src_caught, ifc.rf_we);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_null_write();
      test_rdy_stall();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end
endmodule
